// File: rtl/decoder_1to2.sv
// Enabled 1-to-2 one-hot write-select decoder for the two-entry register file, with registered tracking.
// Define DECODER_1TO2_STATS_EN to add the saturating per-register write counters.
module decoder_1to2 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_addr,
    input  logic             load,
    output logic [1:0]       sel,
    output logic [1:0]       sel_q,
    output logic             last_addr,
    output logic             any_write,
    output logic [CNT_W-1:0] cnt_r0,
    output logic [CNT_W-1:0] cnt_r1
);

    logic [1:0] w_sel;
    logic [1:0] r_sel_q;
    logic       r_last_addr;
    logic       r_any_write;

    // An unknown address falls to the default arm, so no strobe is raised.
    always_comb begin
        w_sel = 2'b00;
        if (load) begin
            case (write_addr)
                1'b0:    w_sel = 2'b01;
                1'b1:    w_sel = 2'b10;
                default: w_sel = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_q     <= 2'b00;
            r_last_addr <= 1'b0;
            r_any_write <= 1'b0;
        end else begin
            r_sel_q <= w_sel;
            if (load) begin
                r_last_addr <= write_addr;
                r_any_write <= 1'b1;
            end
        end
    end

`ifdef DECODER_1TO2_STATS_EN
    logic [CNT_W-1:0] r_cnt_r0;
    logic [CNT_W-1:0] r_cnt_r1;

    // Counters stop at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_r0 <= '0;
            r_cnt_r1 <= '0;
        end else begin
            if (w_sel == 2'b01 && r_cnt_r0 != {CNT_W{1'b1}})
                r_cnt_r0 <= r_cnt_r0 + CNT_W'(1);
            if (w_sel == 2'b10 && r_cnt_r1 != {CNT_W{1'b1}})
                r_cnt_r1 <= r_cnt_r1 + CNT_W'(1);
        end
    end

    assign cnt_r0 = r_cnt_r0;
    assign cnt_r1 = r_cnt_r1;
`else
    assign cnt_r0 = '0;
    assign cnt_r1 = '0;
`endif

    assign sel       = w_sel;
    assign sel_q     = r_sel_q;
    assign last_addr = r_last_addr;
    assign any_write = r_any_write;

endmodule

// File: tb/tb_decoder_1to2.sv
// Randomized and directed bench for decoder_1to2 against a behavioural model.
// Counter expectations follow DECODER_1TO2_STATS_EN exactly as the DUT build does.
module tb_decoder_1to2;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             write_addr = 1'b0;
    logic             load = 1'b0;
    logic [1:0]       sel;
    logic [1:0]       sel_q;
    logic             last_addr;
    logic             any_write;
    logic [CNT_W-1:0] cnt_r0;
    logic [CNT_W-1:0] cnt_r1;

    int checks = 0;
    int errors = 0;

    decoder_1to2 #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .write_addr(write_addr), .load(load),
        .sel(sel), .sel_q(sel_q), .last_addr(last_addr), .any_write(any_write),
        .cnt_r0(cnt_r0), .cnt_r1(cnt_r1)
    );

    always #5 clk = ~clk;

`ifdef DECODER_1TO2_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Behavioural model: the strobe target is 1<<addr when load is high.
    bit m_valid = 1'b0;
    int m_sel_q = 0;
    int m_last  = 0;
    int m_any   = 0;
    int m_c0    = 0;
    int m_c1    = 0;

    function automatic int comb_sel(input logic l, input logic a);
        return l ? (1 << int'(a)) : 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_sel_q = 0; m_last = 0; m_any = 0; m_c0 = 0; m_c1 = 0;
        end else begin
            m_sel_q = comb_sel(load, write_addr);
            if (load) begin
                m_last = int'(write_addr);
                m_any  = 1;
                if (STATS) begin
                    if (write_addr == 1'b0) m_c0 = (m_c0 < CNT_MAX) ? m_c0 + 1 : m_c0;
                    else                    m_c1 = (m_c1 < CNT_MAX) ? m_c1 + 1 : m_c1;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_sel",       int'(sel),       comb_sel(load, write_addr));
            check("m_sel_q",     int'(sel_q),     m_sel_q);
            check("m_last_addr", int'(last_addr), m_last);
            check("m_any_write", int'(any_write), m_any);
            check("m_cnt_r0",    int'(cnt_r0),    m_c0);
            check("m_cnt_r1",    int'(cnt_r1),    m_c1);
            check("m_not_11",    int'(sel == 2'b11), 0);
        end
    end

    // Apply inputs just after an edge and settle to the middle of the high phase.
    task automatic cyc(input logic r, input logic l, input logic a);
        @(posedge clk);
        #1;
        rst = r; load = l; write_addr = a;
        #2;
    endtask

    initial begin
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("rst_sel_q", int'(sel_q), 0);
        check("rst_last",  int'(last_addr), 0);
        check("rst_any",   int'(any_write), 0);
        check("rst_cnt0",  int'(cnt_r0), 0);

        cyc(0, 0, 1);
        check("t1_sel", int'(sel), 0);
        cyc(0, 1, 0);
        check("t1_sel_q", int'(sel_q), 0);
        check("t2_sel",   int'(sel), 1);
        check("t1_any",   int'(any_write), 0);

        cyc(0, 1, 1);
        check("t2_sel_q", int'(sel_q), 1);
        check("t2_last",  int'(last_addr), 0);
        check("t2_any",   int'(any_write), 1);
        check("t3_sel",   int'(sel), 2);

        cyc(0, 0, 0);
        check("t3_sel_q", int'(sel_q), 2);
        check("t3_last",  int'(last_addr), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            check("t4_last",  int'(last_addr), 1);
            check("t4_any",   int'(any_write), 1);
            check("t4_sel_q", int'(sel_q), 0);
        end

        cyc(1, 1, 1);
        check("t5_sel_comb", int'(sel), 2);
        cyc(1, 1, 1);
        check("t5_sel",   int'(sel), 2);
        check("t5_sel_q", int'(sel_q), 0);
        check("t5_any",   int'(any_write), 0);
        check("t5_last",  int'(last_addr), 0);
        check("t5_cnt1",  int'(cnt_r1), 0);

        cyc(0, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 1, 0);
            if (i == 2) check("t6_cnt0_2", int'(cnt_r0), STATS ? 2 : 0);
        end
        check("t6_cnt0_sat", int'(cnt_r0), STATS ? 3 : 0);
        check("t6_cnt1",     int'(cnt_r1), 0);
        check("t6_sel_q",    int'(sel_q), 1);

        for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(0, 24) == 0), 1'($urandom), 1'($urandom));
        end
        cyc(0, 0, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
